// File: rtl/z_seq_sqcsa_if.sv
// rtl/z_seq_sqcsa_if.sv - operand request / result handshake bundle for z_seq_sqcsa
interface z_seq_sqcsa_if #(
  parameter int K = 15
);
  localparam int N = K * (K + 3) / 2;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/z_seq_sqcsa.sv
// rtl/z_seq_sqcsa.sv - sequential square-root carry-select adder/subtractor, S stages per clock
module z_seq_sqcsa #(
  parameter int K = 15,
  parameter int S = 4
) (
  input logic          clk,
  input logic          rst_n,
  z_seq_sqcsa_if.slave bus
);
  localparam int N  = K * (K + 3) / 2;
  localparam int CW = $clog2(2 * K) + 1;
  localparam int SW = $clog2(K);
  localparam logic [CW-1:0] S_INC = CW'(S);
  localparam logic [CW-1:0] K_END = CW'(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  sum_r;
  logic          c_out_r;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  // Per-stage results for both carry-ins, placed at the stage's bit position
  logic [N-1:0] p0   [K];
  logic [N-1:0] p1   [K];
  logic [N-1:0] mask [K];
  logic         c0   [K];
  logic         c1   [K];

  for (genvar j = 0; j < K; j++) begin : g_stage
    localparam int LO = j * (j + 3) / 2;
    localparam int W  = j + 2;
    logic [W:0] r0;
    logic [W:0] r1;
    assign r0      = {1'b0, a_r[LO +: W]} + {1'b0, b_r[LO +: W]};
    assign r1      = r0 + (W + 1)'(1);
    assign p0[j]   = N'(r0[W-1:0]) << LO;
    assign p1[j]   = N'(r1[W-1:0]) << LO;
    assign mask[j] = N'({W{1'b1}}) << LO;
    assign c0[j]   = r0[W];
    assign c1[j]   = r1[W];
  end

  logic [N-1:0] nxt_sum;
  logic         nxt_carry;
  logic         rc;
  logic         last_chunk;
  logic         msb_cin;

  // Running carry ripples through the stages of the current chunk only
  always_comb begin
    nxt_sum   = sum_r;
    nxt_carry = carry;
    rc        = carry;
    for (int j = 0; j < K; j++) begin
      if (CW'(j) >= cnt && CW'(j) < cnt + S_INC) begin
        nxt_sum   = (nxt_sum & ~mask[SW'(j)]) | (rc ? p1[SW'(j)] : p0[SW'(j)]);
        rc        = rc ? c1[SW'(j)] : c0[SW'(j)];
        nxt_carry = rc;
      end
    end
  end

  assign last_chunk = (cnt + S_INC >= K_END);
  assign msb_cin    = nxt_sum[N-1] ^ a_r[N-1] ^ b_r[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.sub ? ~bus.b : bus.b;
            carry      <= bus.sub ? 1'b1 : bus.c_in;
            cnt        <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          sum_r <= nxt_sum;
          carry <= nxt_carry;
          cnt   <= cnt + S_INC;
          if (last_chunk) begin
            c_out_r     <= nxt_carry;
            ovf_r       <= msb_cin ^ nxt_carry;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_z_seq_sqcsa.sv
// tb/tb_z_seq_sqcsa.sv - scoreboard bench for z_seq_sqcsa, directed and multi-config random
module tb_z_seq_sqcsa;
  localparam int MK = 15;
  localparam int MS = 4;
  localparam int MN = 135;
  localparam int MC = 4;
  localparam int NOPS = 1000;
  localparam int RK [4] = '{3, 15, 15, 6};
  localparam int RS [4] = '{3, 1, 4, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_main;
  logic rst_rnd;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rnd_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Directed instance, default configuration
  z_seq_sqcsa_if #(.K(MK)) mbus ();
  z_seq_sqcsa #(.K(MK), .S(MS)) u_main (.clk(clk), .rst_n(rst_main), .bus(mbus));

  logic [MN-1:0] mq_sum [$];
  logic          mq_c   [$];
  logic          mq_o   [$];
  int            mq_acc [$];
  logic          m_prev_ov = 1'b0;

  always @(negedge clk) begin : m_monitor
    if (mbus.out_valid && !m_prev_ov) begin
      chk("main_q_nonempty", 160'(mq_sum.size() != 0), 160'(1));
      if (mq_sum.size() != 0) begin
        logic [MN-1:0] es;
        logic ec, eo;
        int acc;
        es = mq_sum.pop_front();
        ec = mq_c.pop_front();
        eo = mq_o.pop_front();
        acc = mq_acc.pop_front();
        chk("main_sum", 160'(mbus.sum), 160'(es));
        chk("main_c_out", 160'(mbus.c_out), 160'(ec));
        chk("main_ovf", 160'(mbus.ovf), 160'(eo));
        chk("main_latency", 160'(cyc - acc), 160'(MC));
      end
    end
    m_prev_ov = mbus.out_valid;
  end

  task automatic m_issue(input logic [MN-1:0] ta, input logic [MN-1:0] tb, input logic tc,
                         input logic ts, input logic [MN-1:0] es, input logic ec, input logic eo);
    int w;
    @(negedge clk);
    mbus.a = ta;
    mbus.b = tb;
    mbus.c_in = tc;
    mbus.sub = ts;
    mbus.in_valid = 1'b1;
    w = 0;
    while (!mbus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("main_accept_timeout", 160'(w), 160'(0));
    mq_sum.push_back(es);
    mq_c.push_back(ec);
    mq_o.push_back(eo);
    mq_acc.push_back(cyc + 1);
    @(negedge clk);
    mbus.in_valid = 1'b0;
    mbus.a = ~ta;
    mbus.b = ~tb;
    mbus.c_in = ~tc;
    mbus.sub = ~ts;
  endtask

  task automatic m_drain();
    int w;
    w = 0;
    while ((mq_sum.size() != 0 || !mbus.in_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("main_drain", 160'(w < 100), 160'(1));
  endtask

  // Random instances across several (K,S) builds, each with its own scoreboard
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int K = RK[g];
    localparam int S = RS[g];
    localparam int N = K * (K + 3) / 2;
    localparam int C = (K + S - 1) / S;

    z_seq_sqcsa_if #(.K(K)) rbus ();
    z_seq_sqcsa #(.K(K), .S(S)) u_dut (.clk(clk), .rst_n(rst_rnd), .bus(rbus));

    logic [N:0] q_res [$];
    logic       q_o   [$];
    int         q_acc [$];
    logic       prev_ov = 1'b0;

    initial begin : drv
      logic [N-1:0] ta, tb;
      logic tc, ts, eo;
      logic [N:0] r;
      int w;
      rbus.in_valid = 1'b0;
      rbus.a = '0;
      rbus.b = '0;
      rbus.c_in = 1'b0;
      rbus.sub = 1'b0;
      while (!rst_rnd) @(negedge clk);
      for (int i = 0; i < NOPS; i++) begin
        for (int k = 0; k < N; k++) begin
          ta[k] = 1'($urandom_range(0, 1));
          tb[k] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) == 0) ta = '1;
        if ($urandom_range(0, 7) == 0) tb = '0;
        tc = 1'($urandom_range(0, 1));
        ts = 1'($urandom_range(0, 1));
        r = ts ? ({1'b0, ta} + {1'b0, ~tb} + (N + 1)'(1))
               : ({1'b0, ta} + {1'b0, tb} + (N + 1)'(tc));
        eo = ts ? (ta[N-1] != tb[N-1] && r[N-1] != ta[N-1])
                : (ta[N-1] == tb[N-1] && r[N-1] != ta[N-1]);
        @(negedge clk);
        rbus.a = ta;
        rbus.b = tb;
        rbus.c_in = tc;
        rbus.sub = ts;
        rbus.in_valid = 1'b1;
        w = 0;
        while (!rbus.in_ready && w < 400) begin
          @(negedge clk);
          w++;
        end
        if (w >= 400) chk($sformatf("rnd%0d_accept_timeout", g), 160'(w), 160'(0));
        q_res.push_back(r);
        q_o.push_back(eo);
        q_acc.push_back(cyc + 1);
        @(negedge clk);
        rbus.in_valid = 1'b0;
        rbus.a = ~ta;
        rbus.b = ~tb;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      w = 0;
      while ((q_res.size() != 0 || !rbus.in_ready) && w < 500) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("rnd%0d_drain", g), 160'(w < 500), 160'(1));
      rnd_done++;
    end

    always @(negedge clk) begin : mon
      if (rbus.out_valid && !prev_ov) begin
        chk($sformatf("rnd%0d_q_nonempty", g), 160'(q_res.size() != 0), 160'(1));
        if (q_res.size() != 0) begin
          logic [N:0] er;
          logic eov;
          int acc;
          er = q_res.pop_front();
          eov = q_o.pop_front();
          acc = q_acc.pop_front();
          chk($sformatf("rnd%0d_result", g), 160'({rbus.c_out, rbus.sum}), 160'(er));
          chk($sformatf("rnd%0d_ovf", g), 160'(rbus.ovf), 160'(eov));
          chk($sformatf("rnd%0d_latency", g), 160'(cyc - acc), 160'(C));
        end
      end
      prev_ov = rbus.out_valid;
      rbus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : directed
    logic [MN-1:0] ones, msb, s_hold;
    int bad, w;
    ones = '1;
    msb = '0;
    msb[MN-1] = 1'b1;
    rst_main = 1'b0;
    rst_rnd = 1'b0;
    mbus.in_valid = 1'b0;
    mbus.a = '0;
    mbus.b = '0;
    mbus.c_in = 1'b0;
    mbus.sub = 1'b0;
    mbus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 160'(mbus.in_ready), 160'(1));
    chk("reset_out_valid", 160'(mbus.out_valid), 160'(0));
    chk("reset_busy", 160'(mbus.busy), 160'(0));
    chk("reset_sum", 160'(mbus.sum), 160'(0));
    chk("reset_c_out", 160'(mbus.c_out), 160'(0));
    chk("reset_ovf", 160'(mbus.ovf), 160'(0));
    rst_main = 1'b1;
    rst_rnd = 1'b1;

    m_issue(ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    m_drain();
    m_issue(MN'(5), MN'(7), 1'b0, 1'b1, {{134{1'b1}}, 1'b0}, 1'b0, 1'b0);
    m_drain();
    m_issue(ones, ones, 1'b1, 1'b0, ones, 1'b1, 1'b0);
    m_drain();
    m_issue(MN'(7), MN'(5), 1'b0, 1'b1, MN'(2), 1'b1, 1'b0);
    m_drain();
    m_issue(msb, MN'(1), 1'b0, 1'b1, ~msb, 1'b1, 1'b1);
    m_drain();
    m_issue(MN'(48'h1234_5678_9abc), MN'(48'h0edc_ba98_7654), 1'b0, 1'b0,
            MN'(48'h2111_1111_1110), 1'b0, 1'b0);
    m_drain();
    m_issue(MN'(10), MN'(3), 1'b1, 1'b1, MN'(7), 1'b1, 1'b0);
    m_drain();
    m_issue(~msb, MN'(1), 1'b0, 1'b0, msb, 1'b0, 1'b1);
    m_drain();

    // Reset in the middle of a run
    m_issue(ones, MN'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_main = 1'b0;
    #1;
    chk("midrst_sum", 160'(mbus.sum), 160'(0));
    chk("midrst_c_out", 160'(mbus.c_out), 160'(0));
    chk("midrst_ovf", 160'(mbus.ovf), 160'(0));
    chk("midrst_out_valid", 160'(mbus.out_valid), 160'(0));
    chk("midrst_busy", 160'(mbus.busy), 160'(0));
    chk("midrst_in_ready", 160'(mbus.in_ready), 160'(1));
    void'(mq_sum.pop_back());
    void'(mq_c.pop_back());
    void'(mq_o.pop_back());
    void'(mq_acc.pop_back());
    repeat (2) @(negedge clk);
    rst_main = 1'b1;
    bad = 0;
    repeat (MC + 2) begin
      @(negedge clk);
      if (mbus.out_valid) bad++;
    end
    chk("midrst_no_pulse", 160'(bad), 160'(0));
    m_issue(MN'(100), MN'(23), 1'b1, 1'b0, MN'(124), 1'b0, 1'b0);
    m_drain();

    // Back-pressure hold in DONE with a pending request
    mbus.out_ready = 1'b0;
    m_issue(MN'(3), MN'(4), 1'b1, 1'b0, MN'(8), 1'b0, 1'b0);
    w = 0;
    while (!mbus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("hold_reach_done", 160'(mbus.out_valid), 160'(1));
    s_hold = mbus.sum;
    mbus.a = ones;
    mbus.b = ones;
    mbus.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_sum", 160'(mbus.sum), 160'(s_hold));
      chk("hold_in_ready", 160'(mbus.in_ready), 160'(0));
      chk("hold_out_valid", 160'(mbus.out_valid), 160'(1));
    end
    mbus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 160'(mbus.in_ready), 160'(1));
    chk("release_out_valid", 160'(mbus.out_valid), 160'(0));
    chk("release_busy", 160'(mbus.busy), 160'(0));
    chk("release_sum", 160'(mbus.sum), 160'(MN'(8)));
    mbus.in_valid = 1'b0;
    @(negedge clk);
    chk("release_no_accept", 160'(mbus.busy), 160'(0));

    w = 0;
    while (rnd_done < 4 && w < 60000) begin
      @(negedge clk);
      w++;
    end
    chk("rnd_complete", 160'(rnd_done), 160'(4));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
